decode_stage: RTL and testbench

- Clocked decode stage directly downstream of the asynchronous fetch stage.
- Requests instructions from fetch with a two-phase toggle trigger and captures each 32-bit word when fetch's level ready is seen high.
- Splits the ARM word into fields and presents them to execute over a valid/ack level handshake.
- Holds one buffered instruction so the next fetch can overlap a stalled execute.

---
 rtl/decode_stage.sv | 196 +++++++++++++++++++
 tb/tb_decode_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: clocked decode stage sitting behind the asynchronous fetch stage.
// Requests words from fetch with a two-phase toggle, captures each word when
// the synchronised ready level goes high, and hands the decoded ARM fields to
// execute over a valid/ack level handshake. A one-word buffer lets the next
// fetch overlap a stalled execute.
//
// Ports:
//   clk, rstN        clock (rising edge), synchronous active-low reset
//   triggerOut       toggle request to fetch, one word per edge
//   readyIn, dataIn  fetch level ready (async) and 32-bit word
//   validOut, ackIn  handshake to execute
//   instrOut ... linkOut  raw word and decoded fields, registered on load
module decode_stage #(
  parameter int SYNC_STAGES    = 2,
  parameter int LOW_TIMEOUT    = 4,
  parameter int STARTUP_CYCLES = 16,
  parameter int PREFETCH       = 1
) (
  input  logic        clk,
  input  logic        rstN,
  output logic        triggerOut,
  input  logic        readyIn,
  input  logic [31:0] dataIn,
  output logic        validOut,
  input  logic        ackIn,
  output logic [31:0] instrOut,
  output logic [3:0]  condOut,
  output logic [1:0]  classOut,
  output logic [3:0]  opcodeOut,
  output logic        sBitOut,
  output logic [3:0]  rnOut,
  output logic [3:0]  rdOut,
  output logic [3:0]  rmOut,
  output logic        immFlagOut,
  output logic [31:0] immOut,
  output logic        linkOut
);

  localparam int CW = $clog2(STARTUP_CYCLES + LOW_TIMEOUT + 1);
  localparam logic [CW-1:0] START_LAST = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LAST   = CW'(LOW_TIMEOUT);

  typedef enum logic [2:0] {START, REQ, WAIT_LOW, WAIT_HIGH, CAPT} stateT;

  stateT                  state, nextState;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] syncQ;
  logic                   rdyS;
  logic [31:0]            bufQ;
  logic                   bufFull;
  logic                   outFree;
  logic                   doToggle, cntClr, cntInc, capture, load;

  assign rdyS    = syncQ[SYNC_STAGES-1];
  // Output register can take a word if empty or being accepted this cycle.
  assign outFree = !validOut || ackIn;

  always_ff @(posedge clk) begin
    if (!rstN) state <= START;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    doToggle  = 1'b0;
    cntClr    = 1'b0;
    cntInc    = 1'b0;
    capture   = 1'b0;
    load      = 1'b0;
    case (state)
      START: begin
        if (cnt == START_LAST) nextState = REQ;
        else                   cntInc    = 1'b1;
      end
      REQ: begin
        doToggle  = 1'b1;
        cntClr    = 1'b1;
        nextState = WAIT_LOW;
      end
      WAIT_LOW: begin
        // A response faster than the synchroniser never shows rdyS low;
        // the timeout treats it as already complete.
        if (!rdyS || cnt == LOW_LAST) nextState = WAIT_HIGH;
        else                          cntInc    = 1'b1;
      end
      WAIT_HIGH: begin
        if (rdyS) begin
          capture   = 1'b1;
          nextState = CAPT;
        end
      end
      CAPT: begin
        if (bufFull) begin
          if (outFree) begin
            load = 1'b1;
            if (PREFETCH != 0) nextState = REQ;
          end
        end else if (outFree) begin
          // Non-prefetch: buffer already moved, wait for the output to drain.
          nextState = REQ;
        end
      end
      default: nextState = START;
    endcase
  end

  // Decode of the buffered word, registered when it loads into the output.
  logic [1:0]  dCls;
  logic [3:0]  dOpcode;
  logic        dImmFlag, dLink;
  logic [31:0] dImm, imm8Ext;
  logic [4:0]  rotAmt;

  always_comb begin
    imm8Ext = {24'b0, bufQ[7:0]};
    rotAmt  = {bufQ[11:8], 1'b0};
    case (bufQ[27:25])
      3'b000, 3'b001: dCls = 2'd0;
      3'b010, 3'b011: dCls = 2'd1;
      3'b101:         dCls = 2'd2;
      default:        dCls = 2'd3;
    endcase
    dOpcode  = 4'd0;
    dImmFlag = 1'b0;
    dImm     = 32'd0;
    dLink    = 1'b0;
    case (dCls)
      2'd0: begin
        dOpcode  = bufQ[24:21];
        dImmFlag = bufQ[25];
        // Shift by 32 when rotAmt is 0 yields zero, so no special case.
        if (bufQ[25])
          dImm = (imm8Ext >> rotAmt) | (imm8Ext << (6'd32 - {1'b0, rotAmt}));
      end
      2'd1: begin
        dImmFlag = ~bufQ[25];
        dImm     = {20'b0, bufQ[11:0]};
      end
      2'd2: begin
        dLink = bufQ[24];
        dImm  = {{6{bufQ[23]}}, bufQ[23:0], 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      syncQ      <= '0;
      cnt        <= '0;
      triggerOut <= 1'b0;
      bufQ       <= '0;
      bufFull    <= 1'b0;
      validOut   <= 1'b0;
      instrOut   <= '0;
      condOut    <= '0;
      classOut   <= '0;
      opcodeOut  <= '0;
      sBitOut    <= 1'b0;
      rnOut      <= '0;
      rdOut      <= '0;
      rmOut      <= '0;
      immFlagOut <= 1'b0;
      immOut     <= '0;
      linkOut    <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], readyIn};
      if (cntClr)      cnt <= '0;
      else if (cntInc) cnt <= cnt + 1'b1;
      if (doToggle) triggerOut <= ~triggerOut;
      if (capture) begin
        bufQ    <= dataIn;
        bufFull <= 1'b1;
      end else if (load) begin
        bufFull <= 1'b0;
      end
      if (load) begin
        validOut   <= 1'b1;
        instrOut   <= bufQ;
        condOut    <= bufQ[31:28];
        classOut   <= dCls;
        opcodeOut  <= dOpcode;
        sBitOut    <= bufQ[20];
        rnOut      <= bufQ[19:16];
        rdOut      <= bufQ[15:12];
        rmOut      <= bufQ[3:0];
        immFlagOut <= dImmFlag;
        immOut     <= dImm;
        linkOut    <= dLink;
      end else if (validOut && ackIn) begin
        validOut <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a behavioural fetch model that
// answers each triggerOut edge with the next queued word.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstN, triggerOut, readyIn, validOut, ackIn;
  logic [31:0] dataIn, instrOut, immOut;
  logic [3:0]  condOut, opcodeOut, rnOut, rdOut, rmOut;
  logic [1:0]  classOut;
  logic        sBitOut, immFlagOut, linkOut;

  int total = 0;
  int bad   = 0;

  decode_stage #(.SYNC_STAGES(2), .LOW_TIMEOUT(4), .STARTUP_CYCLES(16), .PREFETCH(1)) dut (
    .clk(clk), .rstN(rstN), .triggerOut(triggerOut), .readyIn(readyIn), .dataIn(dataIn),
    .validOut(validOut), .ackIn(ackIn), .instrOut(instrOut), .condOut(condOut),
    .classOut(classOut), .opcodeOut(opcodeOut), .sBitOut(sBitOut), .rnOut(rnOut),
    .rdOut(rdOut), .rmOut(rmOut), .immFlagOut(immFlagOut), .immOut(immOut), .linkOut(linkOut)
  );

  always #5 clk = ~clk;

  // Fetch model: words popped only for requests made out of reset.
  logic [31:0] wordQ[$];
  logic [31:0] fetchWord;
  bit          fast = 1'b0;
  int          lowCycles = 3;
  int          toggleCnt = 0;

  always begin
    @(triggerOut);
    if (rstN === 1'b1) begin
      toggleCnt++;
      fetchWord = (wordQ.size() > 0) ? wordQ.pop_front() : 32'hE1A00000;
    end else begin
      fetchWord = 32'hDEADBEEF;
    end
    #1 readyIn = 1'b0;
    if (fast) #1;
    else repeat (lowCycles) @(negedge clk);
    dataIn  = fetchWord;
    readyIn = 1'b1;
  end

  task automatic ackOne();
    @(negedge clk);
    ackIn = 1'b1;
    @(posedge clk);
    #1;
    ackIn = 1'b0;
  endtask

  task automatic waitValid(output bit ok);
    int n = 0;
    while (!validOut && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = validOut;
  endtask

  // Returns number of edges after release until triggerOut first goes high.
  task automatic countToToggle(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (triggerOut) break;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; ackIn = 1'b0; readyIn = 1'b1; dataIn = '0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (triggerOut !== 1'b0) begin bad++; $display("FAIL reset_trigger got=%b want=0", triggerOut); end
    total++; if (validOut !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", validOut); end
    total++; if (instrOut !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instrOut); end
    total++; if (immOut !== 32'h0 || classOut !== 2'd0) begin bad++; $display("FAIL reset_fields imm=%h cls=%0d want 0", immOut, classOut); end
  endtask

  task automatic test_startup();
    int n;
    bit ok;
    wordQ = '{32'hE3A01005, 32'hE3A014FF, 32'hEBFFFFFE, 32'hE5912004,
              32'hE0821003, 32'hE3A02007, 32'hE3A03008};
    @(negedge clk);
    rstN = 1'b1;
    countToToggle(n);
    // 16 idle edges, the 17th edge issues the first request.
    total++; if (n != 17) begin bad++; $display("FAIL startup_delay got=%0d want=17", n); end
    waitValid(ok);
    total++; if (!ok) begin bad++; $display("FAIL startup_valid timeout got=0 want=1"); end
    total++; if (instrOut !== 32'hE3A01005) begin bad++; $display("FAIL dp_instr got=%h want=e3a01005", instrOut); end
    total++; if (classOut !== 2'd0 || condOut !== 4'hE) begin bad++; $display("FAIL dp_class cls=%0d cond=%h want 0,e", classOut, condOut); end
    total++; if (opcodeOut !== 4'hD) begin bad++; $display("FAIL dp_opcode got=%h want=d", opcodeOut); end
    total++; if (rdOut !== 4'd1 || immFlagOut !== 1'b1) begin bad++; $display("FAIL dp_rd_i rd=%0d i=%b want 1,1", rdOut, immFlagOut); end
    total++; if (immOut !== 32'd5) begin bad++; $display("FAIL dp_imm got=%h want=5", immOut); end
  endtask

  task automatic test_rotate();
    bit ok;
    ackOne();
    waitValid(ok);
    total++; if (!ok || instrOut !== 32'hE3A014FF) begin bad++; $display("FAIL rot_instr got=%h want=e3a014ff", instrOut); end
    total++; if (immOut !== 32'hFF000000) begin bad++; $display("FAIL rot_imm got=%h want=ff000000", immOut); end
  endtask

  task automatic test_branch_ls();
    bit ok;
    ackOne();
    waitValid(ok);
    total++; if (!ok || instrOut !== 32'hEBFFFFFE) begin bad++; $display("FAIL br_instr got=%h want=ebfffffe", instrOut); end
    total++; if (classOut !== 2'd2 || linkOut !== 1'b1) begin bad++; $display("FAIL br_class cls=%0d link=%b want 2,1", classOut, linkOut); end
    total++; if (immOut !== 32'hFFFFFFF8 || opcodeOut !== 4'd0) begin bad++; $display("FAIL br_imm imm=%h op=%h want fffffff8,0", immOut, opcodeOut); end
    ackOne();
    waitValid(ok);
    total++; if (!ok || instrOut !== 32'hE5912004) begin bad++; $display("FAIL ls_instr got=%h want=e5912004", instrOut); end
    total++; if (classOut !== 2'd1 || sBitOut !== 1'b1 || linkOut !== 1'b0) begin bad++; $display("FAIL ls_class cls=%0d s=%b l=%b want 1,1,0", classOut, sBitOut, linkOut); end
    total++; if (rnOut !== 4'd1 || rdOut !== 4'd2 || immFlagOut !== 1'b1) begin bad++; $display("FAIL ls_regs rn=%0d rd=%0d i=%b want 1,2,1", rnOut, rdOut, immFlagOut); end
    total++; if (immOut !== 32'd4 || opcodeOut !== 4'd0) begin bad++; $display("FAIL ls_imm imm=%h op=%h want 4,0", immOut, opcodeOut); end
    repeat (20) @(posedge clk);
  endtask

  // Sub-cycle ready pulses; every word must arrive once, in order.
  task automatic test_fast();
    logic [31:0] exp [3] = '{32'hE0821003, 32'hE3A02007, 32'hE3A03008};
    logic [31:0] obs [3];
    int got = 0;
    int n = 0;
    @(negedge clk);
    fast = 1'b1;
    ackIn = 1'b1;
    while (got < 3 && n < 300) begin
      @(negedge clk);
      n++;
      if (validOut) begin
        obs[got] = instrOut;
        got++;
        if (got == 3) ackIn = 1'b0;
      end
    end
    ackIn = 1'b0;
    fast = 1'b0;
    total++; if (got != 3) begin bad++; $display("FAIL fast_count got=%0d want=3", got); end
    for (int i = 0; i < got; i++) begin
      total++; if (obs[i] !== exp[i]) begin bad++; $display("FAIL fast_word%0d got=%h want=%h", i, obs[i], exp[i]); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int tc0, unstable;
    @(negedge clk);
    rstN = 1'b0;
    repeat (8) @(posedge clk);
    wordQ.delete();
    wordQ = '{32'hE3A0100A, 32'hE3A0200B, 32'hE3A0300C};
    @(negedge clk);
    tc0 = toggleCnt;
    rstN = 1'b1;
    waitValid(ok);
    total++; if (!ok || instrOut !== 32'hE3A0100A) begin bad++; $display("FAIL stall_first got=%h want=e3a0100a", instrOut); end
    unstable = 0;
    repeat (50) begin
      @(negedge clk);
      if (validOut !== 1'b1 || instrOut !== 32'hE3A0100A) unstable++;
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL stall_hold unstable=%0d want=0", unstable); end
    total++; if (toggleCnt - tc0 != 2) begin bad++; $display("FAIL stall_toggles got=%0d want=2", toggleCnt - tc0); end
    ackOne();
    total++; if (validOut !== 1'b1 || instrOut !== 32'hE3A0200B) begin bad++; $display("FAIL stall_next v=%b instr=%h want 1,e3a0200b", validOut, instrOut); end
    total++; if (immOut !== 32'h0B) begin bad++; $display("FAIL stall_imm got=%h want=b", immOut); end
  endtask

  task automatic test_reset_midflight();
    int n = 0;
    int target;
    bit ok;
    lowCycles = 10;
    target = toggleCnt + 1;
    while (toggleCnt < target && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++; if (toggleCnt < target) begin bad++; $display("FAIL mid_request timeout toggles=%0d want=%0d", toggleCnt, target); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    total++; if (validOut !== 1'b0 || triggerOut !== 1'b0) begin bad++; $display("FAIL mid_reset v=%b trig=%b want 0,0", validOut, triggerOut); end
    total++; if (instrOut !== 32'h0) begin bad++; $display("FAIL mid_reset_instr got=%h want=0", instrOut); end
    repeat (12) @(posedge clk);
    wordQ.delete();
    wordQ = '{32'hE3A0400D};
    @(negedge clk);
    rstN = 1'b1;
    countToToggle(n);
    total++; if (n != 17) begin bad++; $display("FAIL restart_delay got=%0d want=17", n); end
    waitValid(ok);
    total++; if (!ok || instrOut !== 32'hE3A0400D) begin bad++; $display("FAIL restart_word got=%h want=e3a0400d", instrOut); end
    lowCycles = 3;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_rotate();
    test_branch_ls();
    test_fast();
    test_stall();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
